// File: rtl/sub_flags_ex_stage_pkg.sv
// Purpose: shared LEGv8 condition-code and NZCV bit-index constants for the EX back end.
// Latency: none (constants only).
// Backpressure: n/a.
package sub_flags_ex_stage_pkg;

  // B.cond condition field encodings
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  // Bit positions inside the {N,Z,C,V} flags word
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/sub_flags_ex_stage_cond_eval.sv
// Purpose: evaluate a B.cond condition field against an NZCV flags word.
// Latency: purely combinational.
// Backpressure: n/a.
// Ports: cond[3:0] condition field, nzcv[3:0] flags {N,Z,C,V}, taken = condition holds.
module legv8_cond_eval
  import sub_flags_ex_stage_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       taken
);

  logic n, z, c, v;

  assign n = nzcv[FLAG_N];
  assign z = nzcv[FLAG_Z];
  assign c = nzcv[FLAG_C];
  assign v = nzcv[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_HS: taken = c;
      COND_LO: taken = ~c;
      COND_MI: taken = n;
      COND_PL: taken = ~n;
      COND_VS: taken = v;
      COND_VC: taken = ~v;
      COND_HI: taken = c & ~z;
      COND_LS: taken = ~c | z;
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = ~z & (n == v);
      COND_LE: taken = z | (n != v);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/sub_flags_ex_stage.sv
// Purpose: LEGv8 EX back end - NZCV derivation, flags register, B.cond decision, EX/MEM register.
// Latency: 1 cycle accept->output; flags_nzcv updates on the accept edge of a flag-setting beat.
// Backpressure: outputs hold while out_valid & !out_ready; SUB_FLAGS_SKID_EN adds one skid entry
//               and makes in_ready flop-based, otherwise in_ready = !out_valid | out_ready.
// Ports: clk/reset_n (async active-low); in_* upstream beat with in_valid/in_ready;
//        out_* registered EX/MEM beat with out_valid/out_ready; flags_nzcv architectural {N,Z,C,V}.
// Config macro: SUB_FLAGS_SKID_EN.
module sub_flags_ex_stage
  import sub_flags_ex_stage_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int RD_BITS = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [WIDTH-1:0]   in_diff,
  input  logic               in_carry,
  input  logic               in_set_flags,
  input  logic               in_is_bcond,
  input  logic [3:0]         in_cond,
  input  logic [RD_BITS-1:0] in_rd,
  input  logic               in_wb_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic [RD_BITS-1:0] out_rd,
  output logic               out_wb_en,
  output logic               out_branch_taken,
  output logic [3:0]         flags_nzcv
);

  localparam int MSB = WIDTH - 1;

  logic               accept;
  logic               cond_true;
  logic               taken_new;
  logic [3:0]         nzcv_new;
  logic [3:0]         flags_q, flags_d;

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_result_q, out_result_d;
  logic [RD_BITS-1:0] out_rd_q, out_rd_d;
  logic               out_wb_en_q, out_wb_en_d;
  logic               out_br_q, out_br_d;

  // Only the sign bits of the operands feed the overflow equation.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{in_a[MSB-1:0], in_b[MSB-1:0]};

  assign accept = in_valid & in_ready;

  always_comb begin
    nzcv_new         = 4'b0000;
    nzcv_new[FLAG_N] = in_diff[MSB];
    nzcv_new[FLAG_Z] = (in_diff == '0);
    nzcv_new[FLAG_C] = in_carry;
    nzcv_new[FLAG_V] = (in_a[MSB] ^ in_b[MSB]) & (in_diff[MSB] ^ in_a[MSB]);
  end

  // The branch always sees the flags as they stood before this beat's edge,
  // even if the same beat also sets flags.
  legv8_cond_eval u_cond_eval (
    .cond  (in_cond),
    .nzcv  (flags_q),
    .taken (cond_true)
  );

  assign taken_new = in_is_bcond & cond_true;

  always_comb begin
    flags_d = flags_q;
    if (accept && in_set_flags) begin
      flags_d = nzcv_new;
    end
  end

`ifdef SUB_FLAGS_SKID_EN
  logic               skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0]   skid_result_q, skid_result_d;
  logic [RD_BITS-1:0] skid_rd_q, skid_rd_d;
  logic               skid_wb_en_q, skid_wb_en_d;
  logic               skid_br_q, skid_br_d;

  // in_ready comes straight from the skid occupancy flop; reset_n only
  // forces it low while reset is held.
  assign in_ready = reset_n & ~skid_valid_q;

  always_comb begin
    out_valid_d   = out_valid_q;
    out_result_d  = out_result_q;
    out_rd_d      = out_rd_q;
    out_wb_en_d   = out_wb_en_q;
    out_br_d      = out_br_q;
    skid_valid_d  = skid_valid_q;
    skid_result_d = skid_result_q;
    skid_rd_d     = skid_rd_q;
    skid_wb_en_d  = skid_wb_en_q;
    skid_br_d     = skid_br_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        // Parked beat is older than anything upstream, so it drains first.
        // No accept can coincide since in_ready is low while the skid is full.
        out_valid_d  = 1'b1;
        out_result_d = skid_result_q;
        out_rd_d     = skid_rd_q;
        out_wb_en_d  = skid_wb_en_q;
        out_br_d     = skid_br_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_result_d = in_diff;
          out_rd_d     = in_rd;
          out_wb_en_d  = in_wb_en;
          out_br_d     = taken_new;
        end
      end
    end else if (accept) begin
      skid_valid_d  = 1'b1;
      skid_result_d = in_diff;
      skid_rd_d     = in_rd;
      skid_wb_en_d  = in_wb_en;
      skid_br_d     = taken_new;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_valid_q  <= 1'b0;
      skid_result_q <= '0;
      skid_rd_q     <= '0;
      skid_wb_en_q  <= 1'b0;
      skid_br_q     <= 1'b0;
    end else begin
      skid_valid_q  <= skid_valid_d;
      skid_result_q <= skid_result_d;
      skid_rd_q     <= skid_rd_d;
      skid_wb_en_q  <= skid_wb_en_d;
      skid_br_q     <= skid_br_d;
    end
  end
`else
  // Single register: ready whenever the slot is empty or being drained this cycle.
  assign in_ready = reset_n & (~out_valid_q | out_ready);

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    out_wb_en_d  = out_wb_en_q;
    out_br_d     = out_br_q;
    if (!out_valid_q || out_ready) begin
      out_valid_d = accept;
      if (accept) begin
        out_result_d = in_diff;
        out_rd_d     = in_rd;
        out_wb_en_d  = in_wb_en;
        out_br_d     = taken_new;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q      <= 4'b0000;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
      out_wb_en_q  <= 1'b0;
      out_br_q     <= 1'b0;
    end else begin
      flags_q      <= flags_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      out_wb_en_q  <= out_wb_en_d;
      out_br_q     <= out_br_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_result       = out_result_q;
  assign out_rd           = out_rd_q;
  assign out_wb_en        = out_wb_en_q;
  assign out_branch_taken = out_br_q;
  assign flags_nzcv       = flags_q;

endmodule

// File: tb/tb_sub_flags_ex_stage.sv
// Bench for sub_flags_ex_stage: directed beats, a queue-based reference model
// and a per-cycle compare of outputs, flags and in_ready against that model.
module tb_sub_flags_ex_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a, in_b, in_diff;
  logic        in_carry, in_set_flags, in_is_bcond;
  logic [3:0]  in_cond;
  logic [4:0]  in_rd;
  logic        in_wb_en;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic        out_branch_taken;
  logic [3:0]  flags_nzcv;

  always #5 clk = ~clk;

  sub_flags_ex_stage #(.WIDTH(64), .RD_BITS(5)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_a             (in_a),
    .in_b             (in_b),
    .in_diff          (in_diff),
    .in_carry         (in_carry),
    .in_set_flags     (in_set_flags),
    .in_is_bcond      (in_is_bcond),
    .in_cond          (in_cond),
    .in_rd            (in_rd),
    .in_wb_en         (in_wb_en),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_rd           (out_rd),
    .out_wb_en        (out_wb_en),
    .out_branch_taken (out_branch_taken),
    .flags_nzcv       (flags_nzcv)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
    logic        wb;
    logic        br;
  } beat_t;

  beat_t      q[$];
  beat_t      nb;
  logic [3:0] m_flags;
  bit         last_acc;
  bit         m_rdy, m_acc, m_em;
  int         acc_cnt = 0;
  int         emit_cnt = 0;
  int         cyc = 0;

  // ARM rule: cond[3:1] selects a base test, cond[0] inverts it (except AL/NV).
  function automatic bit cond_model(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cc, v, base;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cc;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cc && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return (c[3:1] != 3'd7 && c[0]) ? !base : base;
  endfunction

  // Signed overflow from a 65-bit exact subtraction.
  function automatic logic [3:0] flags_of(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] d, input logic c);
    logic [64:0] s;
    s = {a[63], a} - {b[63], b};
    return {d[63], (d == 64'd0), c, (s[64] ^ s[63])};
  endfunction

  function automatic bit model_rdy();
`ifdef SUB_FLAGS_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || (out_ready == 1'b1);
`endif
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_flags  = 4'b0000;
      last_acc = 1'b0;
    end else begin
      cyc++;
      m_rdy = model_rdy();
      m_acc = (in_valid == 1'b1) && m_rdy;
      m_em  = (q.size() > 0) && (out_ready == 1'b1);
      if (m_em) begin
        void'(q.pop_front());
        emit_cnt++;
      end
      if (m_acc) begin
        nb.res = in_diff;
        nb.rd  = in_rd;
        nb.wb  = in_wb_en;
        nb.br  = in_is_bcond && cond_model(in_cond, m_flags);
        q.push_back(nb);
        if (in_set_flags) m_flags = flags_of(in_a, in_b, in_diff, in_carry);
        acc_cnt++;
      end
      last_acc = m_acc;
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
      chk("flags", {60'd0, flags_nzcv}, {60'd0, m_flags});
      chk("in_ready", {63'd0, in_ready}, {63'd0, model_rdy()});
      if (q.size() > 0) begin
        chk("out_result", out_result, q[0].res);
        chk("out_rd", {59'd0, out_rd}, {59'd0, q[0].rd});
        chk("out_wb_en", {63'd0, out_wb_en}, {63'd0, q[0].wb});
        chk("out_branch", {63'd0, out_branch_taken}, {63'd0, q[0].br});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic sf,
                       input logic bc, input logic [3:0] c, input logic [4:0] rd,
                       input logic wb);
    bit done;
    done = 1'b0;
    in_a = a; in_b = b; in_diff = a - b; in_carry = (a >= b);
    in_set_flags = sf; in_is_bcond = bc; in_cond = c; in_rd = rd; in_wb_en = wb;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clk);
      #1;
      if (last_acc) done = 1'b1;
    end
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_set_flags = 1'b0;
    in_is_bcond = 1'b0;
  endtask

  localparam logic [63:0] MINNEG = 64'h8000_0000_0000_0000;

  int e0, c0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_diff = '0; in_carry = 1'b0; in_cond = '0; in_rd = '0; in_wb_en = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_flags", {60'd0, flags_nzcv}, 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // SUBS 5-5 then EQ/NE
    drive(64'd5, 64'd5, 1, 0, 4'h0, 5'd1, 1);
    chk("subs_eq_flags", {60'd0, flags_nzcv}, 64'h6);
    chk("subs_eq_result", out_result, 64'd0);
    drive(64'd0, 64'd0, 0, 1, 4'h0, 5'd0, 0);
    chk("beq_taken", {63'd0, out_branch_taken}, 64'd1);
    drive(64'd0, 64'd0, 0, 1, 4'h1, 5'd0, 0);
    chk("bne_taken", {63'd0, out_branch_taken}, 64'd0);

    // SUBS overflow case then GE/LT/VS
    drive(MINNEG, 64'd1, 1, 0, 4'h0, 5'd2, 1);
    chk("subs_ov_flags", {60'd0, flags_nzcv}, 64'h3);
    chk("subs_ov_result", out_result, 64'h7FFF_FFFF_FFFF_FFFF);
    drive(64'd0, 64'd0, 0, 1, 4'hA, 5'd0, 0);
    chk("bge_taken", {63'd0, out_branch_taken}, 64'd0);
    drive(64'd0, 64'd0, 0, 1, 4'hB, 5'd0, 0);
    chk("blt_taken", {63'd0, out_branch_taken}, 64'd1);
    drive(64'd0, 64'd0, 0, 1, 4'h6, 5'd0, 0);
    chk("bvs_taken", {63'd0, out_branch_taken}, 64'd1);

    // SUB without flags keeps 0110; LO then not taken
    drive(64'd5, 64'd5, 1, 0, 4'h0, 5'd1, 1);
    drive(64'd3, 64'd7, 0, 0, 4'h0, 5'd3, 1);
    chk("sub_result", out_result, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("sub_flags_hold", {60'd0, flags_nzcv}, 64'h6);
    drive(64'd0, 64'd0, 0, 1, 4'h3, 5'd0, 0);
    chk("blo_taken", {63'd0, out_branch_taken}, 64'd0);

    // Flag-setting B.cond: branch on old Z=1, flags become 0011
    drive(MINNEG, 64'd1, 1, 1, 4'h0, 5'd4, 0);
    chk("both_taken_old", {63'd0, out_branch_taken}, 64'd1);
    chk("both_flags_new", {60'd0, flags_nzcv}, 64'h3);
    drive(64'd0, 64'd0, 0, 1, 4'hC, 5'd0, 0);
    chk("bgt_taken", {63'd0, out_branch_taken}, 64'd0);
    idle();
    @(posedge clk); #1;

    // Backpressure: 3 cycles stalled, 3 beats offered
    e0 = emit_cnt;
    out_ready = 1'b0;
    fork
      begin
        @(posedge clk); #1;
`ifdef SUB_FLAGS_SKID_EN
        chk("skid_rdy_1held", {63'd0, in_ready}, 64'd1);
`else
        chk("reg_rdy_1held", {63'd0, in_ready}, 64'd0);
`endif
        @(posedge clk); #1;
        chk("rdy_2held", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        chk("bp_hold_beat1", {59'd0, out_rd}, 64'd11);
        out_ready = 1'b1;
      end
      begin
        drive(64'd100, 64'd1, 0, 0, 4'h0, 5'd11, 1);
        drive(64'd200, 64'd2, 0, 0, 4'h0, 5'd12, 1);
        drive(64'd300, 64'd3, 0, 0, 4'h0, 5'd13, 1);
        idle();
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("bp_emit_count", emit_cnt - e0, 64'd3);
    chk("bp_drained", {63'd0, out_valid}, 64'd0);

    // Full throughput: 8 beats back-to-back
    e0 = emit_cnt;
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      drive(64'(i + 20), 64'(i), 0, 0, 4'h0, 5'(i + 16), 1);
    end
    idle();
    chk("tp_accept_cycles", cyc - c0, 64'd8);
    chk("tp_emit_partial", emit_cnt - e0, 64'd7);
    @(posedge clk); #1;
    chk("tp_emit_all", emit_cnt - e0, 64'd8);

    // Mid-stream async reset with a beat held at the output
    out_ready = 1'b0;
    drive(64'd5, 64'd5, 1, 0, 4'h0, 5'd7, 1);
    idle();
    chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_flags", {60'd0, flags_nzcv}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    #1;
    chk("rel2_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
